ps2_scan_decoder: RTL and testbench

PS2_SCAN_DECODER -- requirements
Module: ps2_scan_decoder

---
 rtl/ps2_scan_decoder_pkg.sv | 26 ++
 rtl/ps2_scan_decoder_frame_rx.sv | 112 +++++++++++
 rtl/ps2_scan_decoder.sv | 103 ++++++++++
 tb/tb_ps2_scan_decoder.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/ps2_scan_decoder_pkg.sv
// Shared constants and types for the PS/2 scan-code decoder.
package ps2_scan_decoder_pkg;

    localparam int unsigned KEYCODE_WIDTH = 9;

    localparam logic [7:0] PREFIX_EXT = 8'hE0;
    localparam logic [7:0] PREFIX_BRK = 8'hF0;

    // Bit positions within an 11-bit frame (0 = start bit)
    localparam logic [3:0] BIT_START  = 4'd0;
    localparam logic [3:0] BIT_DATA7  = 4'd8;
    localparam logic [3:0] BIT_PARITY = 4'd9;
    localparam logic [3:0] BIT_STOP   = 4'd10;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_EXT,
        ST_BRK,
        ST_EXT_BRK
    } byte_state_e;

    function automatic logic is_prefix(input logic [7:0] b);
        return (b == PREFIX_EXT) || (b == PREFIX_BRK);
    endfunction

endpackage

// File: rtl/ps2_scan_decoder_frame_rx.sv
// PS/2 frame receiver: input synchronizers, clock glitch filter,
// mid-frame watchdog and 11-bit frame shift/check.
// byte_valid / frame_err are combinational pulses in the stop-edge cycle.
module ps2_frame_rx #(
    parameter int unsigned FILTER_LEN     = 4,
    parameter int unsigned TIMEOUT_CYCLES = 50000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic [7:0] rx_byte,
    output logic       byte_valid,
    output logic       frame_err
);
    import ps2_scan_decoder_pkg::*;

    localparam int unsigned WD_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [1:0]            clk_sync_q,  clk_sync_d;
    logic [1:0]            data_sync_q, data_sync_d;
    logic [FILTER_LEN-1:0] filt_hist_q, filt_hist_d;
    logic                  filt_q,      filt_d;
    logic [3:0]            bit_cnt_q,   bit_cnt_d;
    logic [7:0]            shift_q,     shift_d;
    logic                  parity_q,    parity_d;
    logic [WD_W-1:0]       wd_q,        wd_d;
    logic                  fall;
    logic                  data_s;

    // Synchronizers and filter: the level only moves once the whole history agrees
    always_comb begin
        clk_sync_d  = {clk_sync_q[0], ps2_clk};
        data_sync_d = {data_sync_q[0], ps2_data};
        filt_hist_d = {filt_hist_q[FILTER_LEN-2:0], clk_sync_q[1]};
        filt_d      = filt_q;
        if (&filt_hist_q) begin
            filt_d = 1'b1;
        end else if (~|filt_hist_q) begin
            filt_d = 1'b0;
        end
        fall   = filt_q & ~filt_d;
        data_s = data_sync_q[1];
    end

    // Frame bit counter, shift register, parity capture and watchdog
    always_comb begin
        bit_cnt_d  = bit_cnt_q;
        shift_d    = shift_q;
        parity_d   = parity_q;
        wd_d       = wd_q;
        byte_valid = 1'b0;
        frame_err  = 1'b0;
        if (fall) begin
            wd_d = '0;
            if (bit_cnt_q == BIT_START) begin
                if (!data_s) begin
                    bit_cnt_d = bit_cnt_q + 4'd1;
                end
            end else if (bit_cnt_q <= BIT_DATA7) begin
                shift_d   = {data_s, shift_q[7:1]};
                bit_cnt_d = bit_cnt_q + 4'd1;
            end else if (bit_cnt_q == BIT_PARITY) begin
                parity_d  = data_s;
                bit_cnt_d = bit_cnt_q + 4'd1;
            end else begin
                bit_cnt_d = BIT_START;
                if (((^shift_q) ^ parity_q) && data_s) begin
                    byte_valid = 1'b1;
                end else begin
                    frame_err = 1'b1;
                end
            end
        end else if (bit_cnt_q != BIT_START) begin
            if (wd_q == WD_W'(TIMEOUT_CYCLES)) begin
                bit_cnt_d = BIT_START;
                shift_d   = '0;
                wd_d      = '0;
            end else begin
                wd_d = wd_q + WD_W'(1);
            end
        end else begin
            wd_d = '0;
        end
    end

    assign rx_byte = shift_q;

    // Receiver state registers; PS/2 lines idle high
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            clk_sync_q  <= '1;
            data_sync_q <= '1;
            filt_hist_q <= '1;
            filt_q      <= 1'b1;
            bit_cnt_q   <= '0;
            shift_q     <= '0;
            parity_q    <= 1'b0;
            wd_q        <= '0;
        end else begin
            clk_sync_q  <= clk_sync_d;
            data_sync_q <= data_sync_d;
            filt_hist_q <= filt_hist_d;
            filt_q      <= filt_d;
            bit_cnt_q   <= bit_cnt_d;
            shift_q     <= shift_d;
            parity_q    <= parity_d;
            wd_q        <= wd_d;
        end
    end

endmodule

// File: rtl/ps2_scan_decoder.sv
// PS/2 scan-code decoder: frame receiver plus E0/F0 prefix byte FSM
// producing registered make/brake/parity_err pulses and keyCode.
module ps2_scan_decoder #(
    parameter int unsigned KEYCODE_WIDTH  = 9,
    parameter int unsigned FILTER_LEN     = 4,
    parameter int unsigned TIMEOUT_CYCLES = 50000
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     ps2_clk,
    input  logic                     ps2_data,
    output logic [KEYCODE_WIDTH-1:0] keyCode,
    output logic                     make,
    output logic                     brake,
    output logic                     parity_err
);
    import ps2_scan_decoder_pkg::*;

    logic [7:0]               rx_byte;
    logic                     byte_valid;
    logic                     frame_err;
    byte_state_e              state_q, state_d;
    logic [KEYCODE_WIDTH-1:0] keycode_q, keycode_d;
    logic                     make_q, make_d;
    logic                     brake_q, brake_d;
    logic                     parity_err_q, parity_err_d;
    logic                     ext, brk;

    ps2_frame_rx #(
        .FILTER_LEN     (FILTER_LEN),
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_frame_rx (
        .clk        (clk),
        .reset      (reset),
        .ps2_clk    (ps2_clk),
        .ps2_data   (ps2_data),
        .rx_byte    (rx_byte),
        .byte_valid (byte_valid),
        .frame_err  (frame_err)
    );

    // State and output registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            keycode_q    <= '0;
            make_q       <= 1'b0;
            brake_q      <= 1'b0;
            parity_err_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            keycode_q    <= keycode_d;
            make_q       <= make_d;
            brake_q      <= brake_d;
            parity_err_q <= parity_err_d;
        end
    end

    // Next-state: prefixes accumulate, a bad frame drops back to IDLE
    always_comb begin
        state_d = state_q;
        if (frame_err) begin
            state_d = ST_IDLE;
        end else if (byte_valid) begin
            unique case (state_q)
                ST_IDLE: begin
                    if (rx_byte == PREFIX_EXT)      state_d = ST_EXT;
                    else if (rx_byte == PREFIX_BRK) state_d = ST_BRK;
                    else                            state_d = ST_IDLE;
                end
                ST_EXT: begin
                    if (rx_byte == PREFIX_BRK)      state_d = ST_EXT_BRK;
                    else if (rx_byte == PREFIX_EXT) state_d = ST_EXT;
                    else                            state_d = ST_IDLE;
                end
                ST_BRK:     state_d = is_prefix(rx_byte) ? ST_BRK : ST_IDLE;
                ST_EXT_BRK: state_d = is_prefix(rx_byte) ? ST_EXT_BRK : ST_IDLE;
                default:    state_d = ST_IDLE;
            endcase
        end
    end

    // Outputs: a non-prefix byte emits make or brake with the extended flag from state
    always_comb begin
        ext          = (state_q == ST_EXT) || (state_q == ST_EXT_BRK);
        brk          = (state_q == ST_BRK) || (state_q == ST_EXT_BRK);
        keycode_d    = keycode_q;
        make_d       = 1'b0;
        brake_d      = 1'b0;
        parity_err_d = frame_err;
        if (byte_valid && !is_prefix(rx_byte)) begin
            keycode_d = KEYCODE_WIDTH'({ext, rx_byte});
            make_d    = !brk;
            brake_d   = brk;
        end
    end

    assign keyCode    = keycode_q;
    assign make       = make_q;
    assign brake      = brake_q;
    assign parity_err = parity_err_q;

endmodule

// File: tb/tb_ps2_scan_decoder.sv
// Testbench for ps2_scan_decoder: directed scenarios plus randomized
// byte streams checked against a prefix-flag reference model.
module tb_ps2_scan_decoder;

    localparam int unsigned TIMEOUT = 200;
    localparam int unsigned HALF    = 20;

    logic       clk = 1'b0;
    logic       reset;
    logic       ps2_clk;
    logic       ps2_data;
    logic [8:0] keyCode;
    logic       make;
    logic       brake;
    logic       parity_err;

    int n_checks = 0;
    int n_fail   = 0;

    // Event = {parity_err, make, brake, keyCode}
    logic [11:0] obs_q[$];
    logic [11:0] exp_q[$];

    // Reference model state: pending prefix flags and last reported code
    bit         m_ext;
    bit         m_brk;
    logic [8:0] m_code;
    logic [8:0] prev_key;

    ps2_scan_decoder #(
        .KEYCODE_WIDTH  (9),
        .FILTER_LEN     (4),
        .TIMEOUT_CYCLES (TIMEOUT)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .ps2_clk    (ps2_clk),
        .ps2_data   (ps2_data),
        .keyCode    (keyCode),
        .make       (make),
        .brake      (brake),
        .parity_err (parity_err)
    );

    always #5 clk = ~clk;

    // Monitor: record every pulse cycle; keyCode may only move with make/brake
    always @(negedge clk) begin
        if (!reset) begin
            if (make || brake || parity_err)
                obs_q.push_back({parity_err, make, brake, keyCode});
            if (keyCode !== prev_key) begin
                n_checks++;
                if (!(make || brake)) begin
                    n_fail++;
                    $display("FAIL keycode_hold: keyCode changed %h -> %h with no make/brake", prev_key, keyCode);
                end
            end
        end
        prev_key = keyCode;
    end

    function automatic void model_reset();
        m_ext  = 1'b0;
        m_brk  = 1'b0;
        m_code = '0;
        obs_q.delete();
        exp_q.delete();
    endfunction

    function automatic void model_frame(input logic [7:0] b, input bit ok);
        if (!ok) begin
            exp_q.push_back({3'b100, m_code});
            m_ext = 1'b0;
            m_brk = 1'b0;
        end else if (b == 8'hE0) begin
            if (!m_brk) m_ext = 1'b1;
        end else if (b == 8'hF0) begin
            m_brk = 1'b1;
        end else begin
            m_code = {m_ext, b};
            exp_q.push_back({1'b0, !m_brk, m_brk, m_code});
            m_ext = 1'b0;
            m_brk = 1'b0;
        end
    endfunction

    function automatic logic [10:0] mk_frame(input logic [7:0] b, input bit bad_par, input bit bad_stop);
        logic par;
        par = (~^b) ^ bad_par;
        return {~bad_stop, par, b, 1'b0};
    endfunction

    task automatic send_bits(input logic [10:0] frame, input int unsigned nbits);
        for (int unsigned i = 0; i < nbits; i++) begin
            ps2_data = frame[i];
            repeat (HALF) @(negedge clk);
            ps2_clk = 1'b0;
            repeat (HALF) @(negedge clk);
            ps2_clk = 1'b1;
        end
        repeat (HALF) @(negedge clk);
        ps2_data = 1'b1;
    endtask

    task automatic send_frame(input logic [7:0] b, input bit bad_par, input bit bad_stop);
        send_bits(mk_frame(b, bad_par, bad_stop), 11);
        model_frame(b, !(bad_par || bad_stop));
    endtask

    task automatic test_reset();
        reset    = 1'b1;
        ps2_clk  = 1'b1;
        ps2_data = 1'b1;
        model_reset();
        repeat (5) @(negedge clk);
        n_checks++; if (keyCode !== 9'h000) begin n_fail++; $display("FAIL reset_keycode: got %h want 000", keyCode); end
        n_checks++; if (make !== 1'b0) begin n_fail++; $display("FAIL reset_make: got %b want 0", make); end
        n_checks++; if (brake !== 1'b0) begin n_fail++; $display("FAIL reset_brake: got %b want 0", brake); end
        n_checks++; if (parity_err !== 1'b0) begin n_fail++; $display("FAIL reset_parity_err: got %b want 0", parity_err); end
        reset = 1'b0;
        repeat (5) @(negedge clk);
    endtask

    task automatic test_make();
        send_frame(8'h1C, 0, 0);
        repeat (20) @(negedge clk);
        n_checks++;
        if (obs_q.size() != exp_q.size()) begin n_fail++; $display("FAIL make_count: got %0d events want %0d", obs_q.size(), exp_q.size()); end
        for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
            n_checks++;
            if (obs_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL make_event[%0d]: got %h want %h", i, obs_q[i], exp_q[i]); end
        end
        obs_q.delete(); exp_q.delete();
    endtask

    task automatic test_extended();
        send_frame(8'hE0, 0, 0);
        send_frame(8'h5A, 0, 0);
        send_frame(8'hE0, 0, 0);
        send_frame(8'hF0, 0, 0);
        send_frame(8'h4A, 0, 0);
        repeat (20) @(negedge clk);
        n_checks++;
        if (obs_q.size() != exp_q.size()) begin n_fail++; $display("FAIL ext_count: got %0d events want %0d", obs_q.size(), exp_q.size()); end
        for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
            n_checks++;
            if (obs_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL ext_event[%0d]: got %h want %h", i, obs_q[i], exp_q[i]); end
        end
        obs_q.delete(); exp_q.delete();
    endtask

    task automatic test_parity();
        send_frame(8'h75, 1, 0);
        send_frame(8'h75, 0, 0);
        send_frame(8'h29, 0, 1);
        send_frame(8'h29, 0, 0);
        repeat (20) @(negedge clk);
        n_checks++;
        if (obs_q.size() != exp_q.size()) begin n_fail++; $display("FAIL parity_count: got %0d events want %0d", obs_q.size(), exp_q.size()); end
        for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
            n_checks++;
            if (obs_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL parity_event[%0d]: got %h want %h", i, obs_q[i], exp_q[i]); end
        end
        obs_q.delete(); exp_q.delete();
    endtask

    task automatic test_timeout();
        send_bits(mk_frame(8'h6C, 0, 0), 5);
        repeat (TIMEOUT + 10) @(negedge clk);
        send_frame(8'h6C, 0, 0);
        repeat (20) @(negedge clk);
        n_checks++;
        if (obs_q.size() != exp_q.size()) begin n_fail++; $display("FAIL timeout_count: got %0d events want %0d", obs_q.size(), exp_q.size()); end
        for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
            n_checks++;
            if (obs_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL timeout_event[%0d]: got %h want %h", i, obs_q[i], exp_q[i]); end
        end
        obs_q.delete(); exp_q.delete();
    endtask

    task automatic test_reset_midframe();
        send_bits(mk_frame(8'h73, 0, 0), 6);
        reset = 1'b1;
        repeat (3) @(negedge clk);
        n_checks++; if (keyCode !== 9'h000) begin n_fail++; $display("FAIL midreset_keycode: got %h want 000", keyCode); end
        n_checks++; if ({make, brake, parity_err} !== 3'b000) begin n_fail++; $display("FAIL midreset_pulses: got %b want 000", {make, brake, parity_err}); end
        model_reset();
        repeat (3) @(negedge clk);
        reset = 1'b0;
        repeat (5) @(negedge clk);
        send_frame(8'h73, 0, 0);
        repeat (20) @(negedge clk);
        n_checks++;
        if (obs_q.size() != exp_q.size()) begin n_fail++; $display("FAIL midreset_count: got %0d events want %0d", obs_q.size(), exp_q.size()); end
        for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
            n_checks++;
            if (obs_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL midreset_event[%0d]: got %h want %h", i, obs_q[i], exp_q[i]); end
        end
        obs_q.delete(); exp_q.delete();
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 3; i++) send_frame(8'h1C, 0, 0);
        repeat (20) @(negedge clk);
        n_checks++;
        if (obs_q.size() != exp_q.size()) begin n_fail++; $display("FAIL b2b_count: got %0d events want %0d", obs_q.size(), exp_q.size()); end
        for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
            n_checks++;
            if (obs_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL b2b_event[%0d]: got %h want %h", i, obs_q[i], exp_q[i]); end
        end
        obs_q.delete(); exp_q.delete();
    endtask

    task automatic test_random();
        logic [7:0]  b;
        int unsigned r;
        for (int n = 0; n < 40; n++) begin
            r = $urandom_range(0, 9);
            b = 8'($urandom);
            case (r)
                0, 1:    send_frame(8'hE0, 0, 0);
                2, 3:    send_frame(8'hF0, 0, 0);
                4:       send_frame(b, 1, 0);
                5:       send_frame(b, 0, 1);
                default: send_frame(b, 0, 0);
            endcase
            repeat ($urandom_range(0, 30)) @(negedge clk);
        end
        send_frame(8'h11, 0, 0);
        repeat (20) @(negedge clk);
        n_checks++;
        if (obs_q.size() != exp_q.size()) begin n_fail++; $display("FAIL random_count: got %0d events want %0d", obs_q.size(), exp_q.size()); end
        for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
            n_checks++;
            if (obs_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL random_event[%0d]: got %h want %h", i, obs_q[i], exp_q[i]); end
        end
        obs_q.delete(); exp_q.delete();
    endtask

    initial begin
        prev_key = '0;
        test_reset();
        test_make();
        test_extended();
        test_parity();
        test_timeout();
        test_back_to_back();
        test_reset_midframe();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
